dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_arbiter_rr_picker.sv | 38 +++
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
package dmem_pkg;

    localparam int unsigned DEF_NUM_CORES = 4;
    localparam int unsigned DEF_ADDR_W    = 16;
    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned CNT_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_e;

    // Index width for a core count; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first requester at or after ptr wins.
module rr_picker
    import dmem_pkg::*;
#(
    parameter int unsigned NUM_CORES = DEF_NUM_CORES,
    parameter int unsigned IDX_W     = idx_width(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_CORES-1:0] grant_c,
    output logic [IDX_W-1:0]     index_c,
    output logic                 valid_c
);

    int unsigned      slot;
    logic [IDX_W-1:0] pos;

    always_comb begin
        grant_c = '0;
        index_c = '0;
        valid_c = 1'b0;
        slot    = 0;
        pos     = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            slot = 32'(ptr) + i;
            if (slot >= NUM_CORES) begin
                slot = slot - NUM_CORES;
            end
            pos = IDX_W'(slot);
            if (!valid_c && req[pos]) begin
                valid_c      = 1'b1;
                grant_c[pos] = 1'b1;
                index_c      = pos;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving several cores shared access to one data memory.
// Each access walks IDLE -> ACCESS -> ACK; all outputs are registered.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned NUM_CORES = DEF_NUM_CORES,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W
) (
    input  logic                          clk,
    input  logic                          RESET,
    input  logic [NUM_CORES-1:0]          core_rd,
    input  logic [NUM_CORES-1:0]          core_wr,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
    output logic [NUM_CORES-1:0]          core_ack,
    output logic [DATA_W-1:0]             core_rdata,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          busy,
    output logic                          err_both,
    output logic [CNT_W-1:0]              access_count
);

    localparam int unsigned IDX_W = idx_width(NUM_CORES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e                 state, state_next;
    logic [IDX_W-1:0]       rr_ptr, rr_ptr_next;
    logic [IDX_W-1:0]       win_idx, win_idx_next;
    logic [NUM_CORES-1:0]   ack_next;
    logic [DATA_W-1:0]      rdata_next;
    logic                   rd_next, wr_next;
    logic [ADDR_W-1:0]      addr_next;
    logic [DATA_W-1:0]      wdata_next;
    logic                   busy_next, err_next;
    logic [CNT_W-1:0]       count_next;

    logic [NUM_CORES-1:0]   req;
    logic [NUM_CORES-1:0]   grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic                   pick_wr;
    logic                   pick_both;
    logic [ADDR_W-1:0]      addr_arr  [NUM_CORES];
    logic [DATA_W-1:0]      wdata_arr [NUM_CORES];

    // Unpack the flat per-core address and data buses.
    always_comb begin
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            addr_arr[k]  = core_addr[k*ADDR_W +: ADDR_W];
            wdata_arr[k] = core_wdata[k*DATA_W +: DATA_W];
        end
    end

    assign req = core_rd | core_wr;

    rr_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req     (req),
        .ptr     (rr_ptr),
        .grant_c (grant),
        .index_c (pick_idx),
        .valid_c (pick_valid)
    );

    // A core raising both rd and wr is served as a write.
    assign pick_wr   = |(grant & core_wr);
    assign pick_both = |(grant & core_rd & core_wr);

    // Next-state and next-output logic; strobes and ack default low every cycle.
    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        win_idx_next = win_idx;
        ack_next    = '0;
        rdata_next  = core_rdata;
        rd_next     = 1'b0;
        wr_next     = 1'b0;
        addr_next   = '0;
        wdata_next  = '0;
        busy_next   = busy;
        err_next    = err_both;
        count_next  = access_count;

        unique case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next   = ST_ACCESS;
                    win_idx_next = pick_idx;
                    rr_ptr_next  = (pick_idx == IDX_W'(NUM_CORES - 1)) ? '0
                                                                        : pick_idx + IDX_W'(1);
                    rd_next      = ~pick_wr;
                    wr_next      = pick_wr;
                    addr_next    = addr_arr[pick_idx];
                    wdata_next   = pick_wr ? wdata_arr[pick_idx] : '0;
                    busy_next    = 1'b1;
                    if (pick_both) begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                state_next        = ST_ACK;
                ack_next[win_idx] = 1'b1;
                if (!mem_write) begin
                    rdata_next = mem_rdata;
                end
            end
            ST_ACK: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
                if (access_count != CNT_MAX) begin
                    count_next = access_count + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // Reset cuts any in-flight strobe immediately and drops the pending ack.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            win_idx      <= '0;
            core_ack     <= '0;
            core_rdata   <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
            err_both     <= 1'b0;
            access_count <= '0;
        end else begin
            state        <= state_next;
            rr_ptr       <= rr_ptr_next;
            win_idx      <= win_idx_next;
            core_ack     <= ack_next;
            core_rdata   <= rdata_next;
            mem_read     <= rd_next;
            mem_write    <= wr_next;
            mem_addr     <= addr_next;
            mem_wdata    <= wdata_next;
            busy         <= busy_next;
            err_both     <= err_next;
            access_count <= count_next;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected grants are queued at request time
// and retired as acks appear, with a small memory model answering reads.
module tb_dmem_arbiter;

    localparam int unsigned NC = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic              clk = 1'b0;
    logic              RESET;
    logic [NC-1:0]     core_rd, core_wr;
    logic [NC*AW-1:0]  core_addr;
    logic [NC*DW-1:0]  core_wdata;
    logic [NC-1:0]     core_ack;
    logic [DW-1:0]     core_rdata;
    logic              mem_read, mem_write;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              busy, err_both;
    logic [15:0]       access_count;

    always #5 clk = ~clk;

    dmem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .RESET        (RESET),
        .core_rd      (core_rd),
        .core_wr      (core_wr),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_ack     (core_ack),
        .core_rdata   (core_rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .err_both     (err_both),
        .access_count (access_count)
    );

    logic [DW-1:0] mem_model [256];
    assign mem_rdata = mem_model[mem_addr[7:0]];

    typedef struct {
        int          core;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          issue;
        int          lat;
    } item_t;

    item_t        sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           n_wr_strobe = 0;
    int           hold [NC];
    bit [NC-1:0]  drop_pend = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic req(input int k, input bit rd, input bit wr,
                       input logic [15:0] a, input logic [15:0] d, input int hold_n);
        core_addr[k*AW +: AW]  = a;
        core_wdata[k*DW +: DW] = d;
        core_rd[k] = rd;
        core_wr[k] = wr;
        hold[k]    = hold_n;
    endtask

    task automatic push(input int k, input bit wr, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] rdata, input int lat);
        item_t it;
        it.core = k; it.wr = wr; it.addr = a; it.wdata = d;
        it.rdata = rdata; it.issue = cyc; it.lat = lat;
        sb.push_back(it);
    endtask

    // One clock: release finished requesters, then check bus and acks against the queue.
    task automatic tick();
        item_t it;
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NC; k++) begin
            if (drop_pend[k]) begin
                core_rd[k]   = 1'b0;
                core_wr[k]   = 1'b0;
                drop_pend[k] = 1'b0;
            end
        end
        if (mem_read || mem_write) begin
            if (mem_write) n_wr_strobe++;
            check("busy_in_access", 32'(busy), 32'd1);
            check("single_strobe", 32'(mem_read & mem_write), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_access", 32'd1, 32'd0);
            end else begin
                it = sb[0];
                check("access_is_write", 32'(mem_write), 32'(it.wr));
                check("access_addr", 32'(mem_addr), 32'(it.addr));
                if (it.wr) begin
                    check("access_wdata", 32'(mem_wdata), 32'(it.wdata));
                    mem_model[mem_addr[7:0]] = mem_wdata;
                end
            end
        end else begin
            check("idle_bus", {mem_addr, mem_wdata}, 32'd0);
        end
        if (core_ack != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(core_ack), 32'd0);
            end else begin
                it = sb.pop_front();
                check("ack_core", 32'(core_ack), 32'd1 << it.core);
                if (!it.wr) check("rdata", 32'(core_rdata), 32'(it.rdata));
                if (it.lat != 0) check("ack_latency", 32'(cyc - it.issue + 1), 32'(it.lat));
            end
            for (int k = 0; k < NC; k++) begin
                if (core_ack[k]) begin
                    hold[k]--;
                    if (hold[k] <= 0) drop_pend[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check("timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        RESET = 1'b1;
        core_rd = '0; core_wr = '0; core_addr = '0; core_wdata = '0;
        for (int i = 0; i < 256; i++) mem_model[i] = '0;
        for (int k = 0; k < NC; k++) hold[k] = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(core_ack), 32'd0);
        check("rst_rdata", 32'(core_rdata), 32'd0);
        check("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
        check("rst_bus", {mem_addr, mem_wdata}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_both), 32'd0);
        check("rst_count", 32'(access_count), 32'd0);
        RESET = 1'b0;
        tick();

        // Contention from reset: grants 0,1,2,3 spaced three cycles apart.
        req(0, 0, 1, 16'h0030, 16'h1111, 1);
        req(1, 1, 0, 16'h0030, 16'h0000, 1);
        req(2, 0, 1, 16'h0031, 16'h2222, 1);
        req(3, 1, 0, 16'h0031, 16'h0000, 1);
        push(0, 1, 16'h0030, 16'h1111, 16'h0000, 3);
        push(1, 0, 16'h0030, 16'h0000, 16'h1111, 6);
        push(2, 1, 16'h0031, 16'h2222, 16'h0000, 9);
        push(3, 0, 16'h0031, 16'h0000, 16'h2222, 12);
        wait_done(40);
        check("count_contention", 32'(access_count), 32'd4);

        // Single write from core 2.
        wr0 = n_wr_strobe;
        req(2, 0, 1, 16'h0010, 16'hBEEF, 1);
        push(2, 1, 16'h0010, 16'hBEEF, 16'h0000, 3);
        wait_done(20);
        check("write_strobe_cycles", 32'(n_wr_strobe - wr0), 32'd1);
        check("count_write", 32'(access_count), 32'd5);
        check("rdata_hold", 32'(core_rdata), 32'h2222);

        // Single read from core 0.
        req(0, 1, 0, 16'h0010, 16'h0000, 1);
        push(0, 0, 16'h0010, 16'h0000, 16'hBEEF, 3);
        wait_done(20);
        check("count_read", 32'(access_count), 32'd6);

        // Fairness: core 0 keeps requesting, core 3 arrives one cycle later.
        req(0, 1, 0, 16'h0010, 16'h0000, 2);
        push(0, 0, 16'h0010, 16'h0000, 16'hBEEF, 3);
        tick();
        req(3, 0, 1, 16'h0040, 16'h3333, 1);
        push(3, 1, 16'h0040, 16'h3333, 16'h0000, 5);
        push(0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0);
        wait_done(40);
        check("count_fair", 32'(access_count), 32'd9);

        // Conflicting rd+wr from core 1 is served as a write and flagged.
        req(1, 1, 1, 16'h0050, 16'h5A5A, 1);
        push(1, 1, 16'h0050, 16'h5A5A, 16'h0000, 3);
        wait_done(20);
        check("err_set", 32'(err_both), 32'd1);
        req(2, 1, 0, 16'h0050, 16'h0000, 1);
        push(2, 0, 16'h0050, 16'h0000, 16'h5A5A, 3);
        wait_done(20);
        check("err_sticky", 32'(err_both), 32'd1);
        check("count_conflict", 32'(access_count), 32'd11);

        // Reset during a write ACCESS.
        req(2, 0, 1, 16'h0060, 16'h7777, 1);
        push(2, 1, 16'h0060, 16'h7777, 16'h0000, 3);
        tick();
        check("pre_reset_write", 32'(mem_write), 32'd1);
        #2 RESET = 1'b1;
        #1;
        check("reset_cut_write", 32'(mem_write), 32'd0);
        check("reset_bus", {mem_addr, mem_wdata}, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err", 32'(err_both), 32'd0);
        check("reset_count", 32'(access_count), 32'd0);
        sb.delete();
        core_rd = '0; core_wr = '0; drop_pend = '0;
        tick();
        tick();
        RESET = 1'b0;
        repeat (4) tick();
        check("post_reset_count", 32'(access_count), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_rdata", 32'(core_rdata), 32'd0);

        // Round-robin pointer restarts at core 0 after reset.
        req(3, 0, 1, 16'h0070, 16'h0001, 1);
        req(0, 0, 1, 16'h0071, 16'h0002, 1);
        push(0, 1, 16'h0071, 16'h0002, 16'h0000, 3);
        push(3, 1, 16'h0070, 16'h0001, 16'h0000, 6);
        wait_done(30);
        check("count_after_reset", 32'(access_count), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
